// File: rtl/bos_link_pkg.sv
// Shared uplink framing definitions: header byte, arbiter FSM states and the
// channel-index width helper also used by the PC command decoder.
package bos_link_pkg;

   localparam logic [7:0] LINK_HDR = 8'hAA;

   typedef enum logic [2:0] {
      IDLE,
      S_HDR,
      S_ADDR,
      S_RD,
      S_FETCH,
      S_DATA,
      S_LEN,
      S_CSUM
   } link_state_t;

   // Bits needed to index n channels; never below 1 so a 1-channel build still has a port.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel at or after ptr, wrapping.
// Purely combinational; the caller registers whatever it keeps.
module rr_arbiter
   import bos_link_pkg::*;
#(
   parameter int unsigned N_CH = 5,
   localparam int unsigned CH_W = ch_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   input  logic            en,
   output logic [CH_W-1:0] gnt_idx,
   output logic            gnt_valid
);

   int unsigned idx;

   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         idx = (32'(ptr) + k) % N_CH;
         if (en && !gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uplink_msg_arbiter.sv
// Drains one requesting channel at a time into an uplink frame:
// HDR, ADDR, payload (1..MAX_LEN bytes), LEN, CSUM (XOR of ADDR..LEN).
module uplink_msg_arbiter
   import bos_link_pkg::*;
#(
   parameter int unsigned N_CH    = 5,
   parameter int unsigned MAX_LEN = 255,
   parameter logic [7:0]  HDR     = LINK_HDR,
   localparam int unsigned CH_W   = ch_w(N_CH)
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   have_msg_bus,
   input  logic [8*N_CH-1:0] slave_data_bus,
   output logic [N_CH-1:0]   rdreq_bus,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic [CH_W-1:0]   cur_ch
);

   localparam logic [8:0] LEN_LIM = 9'(MAX_LEN);

   link_state_t     state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [7:0]      count_q, count_d;
   logic [7:0]      csum_q, csum_d;
   logic [N_CH-1:0] rdreq_d;
   logic [7:0]      tx_data_d;
   logic            tx_valid_d;
   logic [CH_W-1:0] cur_ch_d;

   logic [CH_W-1:0] gnt_idx;
   logic            gnt_valid;
   logic            accept;
   logic            have_cur;
   logic [8:0]      count_inc;
   logic [N_CH-1:0] ch_onehot;
   logic [7:0]      slave_byte [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_byte
      assign slave_byte[g] = slave_data_bus[8*g +: 8];
   end

   assign accept    = tx_valid & tx_ready;
   assign have_cur  = have_msg_bus[cur_ch];
   assign count_inc = 9'(count_q) + 9'd1;
   assign ch_onehot = N_CH'(1) << cur_ch;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req       (have_msg_bus),
      .ptr       (ptr_q),
      .en        (state_q == IDLE),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // rdreq is decided on the cycle that leaves ADDR/DATA so the registered
   // strobe lands in S_RD and the FIFO byte is ready during S_FETCH.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      csum_d     = csum_q;
      rdreq_d    = '0;
      tx_data_d  = tx_data;
      tx_valid_d = tx_valid;
      cur_ch_d   = cur_ch;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               cur_ch_d   = gnt_idx;
               count_d    = '0;
               csum_d     = '0;
               tx_data_d  = HDR;
               tx_valid_d = 1'b1;
               state_d    = S_HDR;
            end
         end
         S_HDR: begin
            if (accept) begin
               tx_data_d = 8'(cur_ch);
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (accept) begin
               csum_d     = csum_q ^ tx_data;
               tx_valid_d = 1'b0;
               state_d    = S_RD;
               if (have_cur && (9'(count_q) < LEN_LIM)) rdreq_d = ch_onehot;
            end
         end
         S_RD: begin
            if (|rdreq_bus) begin
               state_d = S_FETCH;
            end else begin
               tx_data_d  = count_q;
               tx_valid_d = 1'b1;
               state_d    = S_LEN;
            end
         end
         S_FETCH: begin
            tx_data_d  = slave_byte[cur_ch];
            tx_valid_d = 1'b1;
            state_d    = S_DATA;
         end
         S_DATA: begin
            if (accept) begin
               csum_d     = csum_q ^ tx_data;
               count_d    = count_inc[7:0];
               tx_valid_d = 1'b0;
               state_d    = S_RD;
               if (have_cur && (count_inc < LEN_LIM)) rdreq_d = ch_onehot;
            end
         end
         S_LEN: begin
            if (accept) begin
               csum_d    = csum_q ^ count_q;
               tx_data_d = csum_q ^ count_q;
               state_d   = S_CSUM;
            end
         end
         S_CSUM: begin
            if (accept) begin
               tx_valid_d = 1'b0;
               ptr_d      = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         count_q   <= '0;
         csum_q    <= '0;
         rdreq_bus <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         busy      <= 1'b0;
         cur_ch    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         csum_q    <= csum_d;
         rdreq_bus <= rdreq_d;
         tx_data   <= tx_data_d;
         tx_valid  <= tx_valid_d;
         busy      <= (state_d != IDLE);
         cur_ch    <= cur_ch_d;
      end
   end

endmodule

// File: tb/tb_uplink_msg_arbiter.sv
// Directed bench for uplink_msg_arbiter: non-show-ahead FIFO models per channel,
// a byte monitor on the uplink, and hand-computed expected frames.
module tb_uplink_msg_arbiter;

   localparam int unsigned N_CH = 5;
   localparam int unsigned CH_W = 3;

   logic              sys_clk = 1'b0;
   logic              rst;
   logic [N_CH-1:0]   have_msg_bus;
   logic [8*N_CH-1:0] slave_data_bus;
   logic [N_CH-1:0]   rdreq_bus;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic [CH_W-1:0]   cur_ch;

   uplink_msg_arbiter #(.N_CH(N_CH), .MAX_LEN(4)) dut (
      .sys_clk        (sys_clk),
      .rst            (rst),
      .have_msg_bus   (have_msg_bus),
      .slave_data_bus (slave_data_bus),
      .rdreq_bus      (rdreq_bus),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .cur_ch         (cur_ch)
   );

   always #5 sys_clk = ~sys_clk;

   // Channel FIFO models: written by the stimulus, popped by rdreq, data one cycle later.
   logic [7:0] mem [N_CH][32];
   int         wr_idx [N_CH] = '{default: 0};
   int         rd_idx [N_CH] = '{default: 0};
   logic [7:0] slave_byte [N_CH] = '{default: 8'h00};

   always @(posedge sys_clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (rdreq_bus[i]) begin
            slave_byte[i] <= mem[i][rd_idx[i]];
            rd_idx[i]     <= rd_idx[i] + 1;
         end
      end
   end

   always_comb begin
      have_msg_bus   = '0;
      slave_data_bus = '0;
      for (int i = 0; i < N_CH; i++) begin
         have_msg_bus[i]         = (wr_idx[i] != rd_idx[i]);
         slave_data_bus[8*i +: 8] = slave_byte[i];
      end
   end

   // Uplink monitor: records every accepted byte and counts read strobes.
   logic [7:0] rx_mem [512];
   int         rx_n = 0;
   int         rd_pulses [N_CH] = '{default: 0};
   int         multi_err = 0;

   always @(negedge sys_clk) begin
      if (!rst && tx_valid && tx_ready) begin
         rx_mem[rx_n] <= tx_data;
         rx_n         <= rx_n + 1;
      end
      for (int i = 0; i < N_CH; i++)
         if (rdreq_bus[i]) rd_pulses[i] <= rd_pulses[i] + 1;
      if (!$onehot0(rdreq_bus)) multi_err <= multi_err + 1;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int rx_rd    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [7:0] b);
      mem[ch][wr_idx[ch]] = b;
      wr_idx[ch]          = wr_idx[ch] + 1;
   endtask

   task automatic check_frame(input string tag, input int n,
                              input logic [7:0] b0 = 0, input logic [7:0] b1 = 0,
                              input logic [7:0] b2 = 0, input logic [7:0] b3 = 0,
                              input logic [7:0] b4 = 0, input logic [7:0] b5 = 0,
                              input logic [7:0] b6 = 0, input logic [7:0] b7 = 0);
      logic [7:0] e [8];
      int w;
      e = '{b0, b1, b2, b3, b4, b5, b6, b7};
      w = 0;
      while ((rx_n - rx_rd) < n && w < 300) begin
         @(negedge sys_clk);
         w++;
      end
      if ((rx_n - rx_rd) < n) begin
         chk({tag, "_timeout"}, 32'(rx_n - rx_rd), 32'(n));
         rx_rd = rx_n;
         return;
      end
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s[%0d]", tag, k), 32'(rx_mem[rx_rd]), 32'(e[k]));
         rx_rd++;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < 50) begin
         tick();
         w++;
      end
   endtask

   task automatic wait_rd(input int ch, input string tag);
      int w;
      w = 0;
      while (!rdreq_bus[ch] && w < 100) begin
         tick();
         w++;
      end
      if (!rdreq_bus[ch]) chk(tag, 32'(rdreq_bus[ch]), 32'd1);
   endtask

   initial begin
      int base;
      logic [7:0] d0;
      int stall_err;

      rst      = 1'b1;
      tx_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_rdreq", 32'(rdreq_bus), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_ch", 32'(cur_ch), 32'd0);

      // 1: single channel, three bytes
      base = rd_pulses[2];
      push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
      check_frame("t1", 7, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h33, 8'h03, 8'h01);
      wait_idle();
      chk("t1_rdreq_ch2", 32'(rd_pulses[2] - base), 32'd3);
      chk("t1_busy", 32'(busy), 32'd0);

      // 2: simultaneous requests, round-robin order
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push(0, 8'h05);
      push(3, 8'h07); push(3, 8'h08);
      check_frame("t2a", 5, 8'hAA, 8'h00, 8'h05, 8'h01, 8'h04);
      check_frame("t2b", 6, 8'hAA, 8'h03, 8'h07, 8'h08, 8'h02, 8'h0E);
      wait_idle();
      chk("t2_cur_ch", 32'(cur_ch), 32'd3);
      push(3, 8'h09);
      push(4, 8'h0A);
      check_frame("t2c", 5, 8'hAA, 8'h04, 8'h0A, 8'h01, 8'h0F);
      check_frame("t2d", 5, 8'hAA, 8'h03, 8'h09, 8'h01, 8'h0B);
      wait_idle();

      // 3: message longer than MAX_LEN=4 is split
      base = rd_pulses[1];
      for (int k = 0; k < 6; k++) push(1, 8'hA0 + 8'(k));
      check_frame("t3a", 8, 8'hAA, 8'h01, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h04, 8'h05);
      check_frame("t3b", 6, 8'hAA, 8'h01, 8'hA4, 8'hA5, 8'h02, 8'h02);
      wait_idle();
      chk("t3_rdreq_ch1", 32'(rd_pulses[1] - base), 32'd6);

      // 4: backpressure during a payload byte
      push(0, 8'hC1); push(0, 8'hC2);
      wait_rd(0, "t4_rdreq_timeout");
      tx_ready = 1'b0;
      tick();
      tick();
      d0 = tx_data;
      chk("t4_data", 32'(d0), 32'hC1);
      chk("t4_valid", 32'(tx_valid), 32'd1);
      stall_err = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge sys_clk);
         if (tx_data !== d0 || tx_valid !== 1'b1 || rdreq_bus !== '0) stall_err++;
      end
      chk("t4_stall_stable", 32'(stall_err), 32'd0);
      tick();
      tx_ready = 1'b1;
      check_frame("t4", 6, 8'hAA, 8'h00, 8'hC1, 8'hC2, 8'h02, 8'h01);
      wait_idle();

      // 5: have_msg drops after one fetched byte
      push(4, 8'hB0);
      check_frame("t5", 5, 8'hAA, 8'h04, 8'hB0, 8'h01, 8'hB5);
      wait_idle();

      // 6: reset mid-payload; pointer returns to 0 (it was 3 before)
      push(2, 8'h55);
      check_frame("t6_pre", 5, 8'hAA, 8'h02, 8'h55, 8'h01, 8'h56);
      wait_idle();
      push(3, 8'hD0); push(3, 8'hD1); push(3, 8'hD2);
      wait_rd(3, "t6_rdreq_timeout");
      tx_ready = 1'b0;
      tick();
      tick();
      push(1, 8'hE0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_tx_valid", 32'(tx_valid), 32'd0);
      chk("t6_rdreq", 32'(rdreq_bus), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_cur_ch", 32'(cur_ch), 32'd0);
      rx_rd    = rx_n;
      tx_ready = 1'b1;
      check_frame("t6a", 5, 8'hAA, 8'h01, 8'hE0, 8'h01, 8'hE0);
      check_frame("t6b", 6, 8'hAA, 8'h03, 8'hD1, 8'hD2, 8'h02, 8'h02);
      wait_idle();

      chk("rdreq_onehot", 32'(multi_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
